// File: rtl/head_ptr_unit.sv
// Tape-head controller: owns the data-tape head pointer, steps multi-cell moves one
// cell per clock, supports direct load and a small save/restore stack of positions.
module head_ptr_unit #(
    parameter int ADDR_W      = 8,
    parameter int STEP_W      = 4,
    parameter int STACK_DEPTH = 4,
    parameter int WRAP_MODE   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_amount,
    input  logic [ADDR_W-1:0] load_value,
    output logic              cmd_ready,
    output logic [ADDR_W-1:0] head_ptr,
    output logic              head_step,
    output logic              busy,
    output logic              bound_fault,
    output logic              stack_err,
    output logic              stack_empty,
    output logic              stack_full
);

    // state     | meaning
    // ST_IDLE   | accepting commands
    // ST_MOVING | stepping the rest of a multi-cell move, commands ignored
    typedef enum logic {ST_IDLE, ST_MOVING} state_t;

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] OP_MVR       = 3'd1;
    localparam logic [2:0] OP_MVL       = 3'd2;
    localparam logic [2:0] OP_LOAD      = 3'd3;
    localparam logic [2:0] OP_PUSH      = 3'd4;
    localparam logic [2:0] OP_POP       = 3'd5;
    localparam logic [2:0] OP_CLR_FAULT = 3'd6;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_head;
    logic [STEP_W-1:0]   r_remaining;
    logic                r_dir;
    logic                r_head_step;
    logic                r_bound_fault;
    logic                r_stack_err;
    logic [DEPTH_W-1:0]  r_depth;
    logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_head_nxt;
    logic [STEP_W-1:0]   w_remaining_nxt;
    logic                w_dir_nxt;
    logic                w_stepped;
    logic                w_bound_fault_nxt;
    logic                w_stack_err_nxt;
    logic [DEPTH_W-1:0]  w_depth_nxt;
    logic                w_push;
    logic                w_step_en;
    logic                w_step_dir;
    logic                w_blocked;
    logic                w_accept;
    logic                w_full;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_top;

    assign w_accept = cmd_valid && (r_state == ST_IDLE);
    assign w_full   = (r_depth == DEPTH_W'(STACK_DEPTH));
    assign w_empty  = (r_depth == '0);

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_depth == DEPTH_W'(i + 1)) begin
                w_top = r_stack[i];
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_head_nxt        = r_head;
        w_remaining_nxt   = r_remaining;
        w_dir_nxt         = r_dir;
        w_stepped         = 1'b0;
        w_bound_fault_nxt = r_bound_fault;
        w_stack_err_nxt   = r_stack_err;
        w_depth_nxt       = r_depth;
        w_push            = 1'b0;
        w_step_en         = 1'b0;
        w_step_dir        = r_dir;
        w_blocked         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_MVR, OP_MVL: begin
                            if (cmd_amount != '0) begin
                                w_step_en       = 1'b1;
                                w_step_dir      = (cmd_op == OP_MVR);
                                w_dir_nxt       = w_step_dir;
                                w_remaining_nxt = cmd_amount - STEP_W'(1);
                                w_state_nxt     = (cmd_amount > STEP_W'(1)) ? ST_MOVING : ST_IDLE;
                            end
                        end
                        OP_LOAD: w_head_nxt = load_value;
                        OP_PUSH: begin
                            if (w_full) begin
                                w_stack_err_nxt = 1'b1;
                            end else begin
                                w_push      = 1'b1;
                                w_depth_nxt = r_depth + DEPTH_W'(1);
                            end
                        end
                        OP_POP: begin
                            if (w_empty) begin
                                w_stack_err_nxt = 1'b1;
                            end else begin
                                w_head_nxt  = w_top;
                                w_depth_nxt = r_depth - DEPTH_W'(1);
                            end
                        end
                        OP_CLR_FAULT: begin
                            w_bound_fault_nxt = 1'b0;
                            w_stack_err_nxt   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MOVING: begin
                w_step_en       = 1'b1;
                w_remaining_nxt = r_remaining - STEP_W'(1);
                w_state_nxt     = (r_remaining == STEP_W'(1)) ? ST_IDLE : ST_MOVING;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // In saturate mode a step off either end is dropped and aborts the rest of the move.
        if (w_step_en) begin
            w_blocked = (WRAP_MODE == 0) &&
                        (w_step_dir ? (r_head == {ADDR_W{1'b1}}) : (r_head == '0));
            if (w_blocked) begin
                w_bound_fault_nxt = 1'b1;
                w_remaining_nxt   = '0;
                w_state_nxt       = ST_IDLE;
            end else begin
                w_head_nxt = w_step_dir ? (r_head + ADDR_W'(1)) : (r_head - ADDR_W'(1));
                w_stepped  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_head        <= '0;
            r_remaining   <= '0;
            r_dir         <= 1'b0;
            r_head_step   <= 1'b0;
            r_bound_fault <= 1'b0;
            r_stack_err   <= 1'b0;
            r_depth       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_head        <= w_head_nxt;
            r_remaining   <= w_remaining_nxt;
            r_dir         <= w_dir_nxt;
            r_head_step   <= w_stepped;
            r_bound_fault <= w_bound_fault_nxt;
            r_stack_err   <= w_stack_err_nxt;
            r_depth       <= w_depth_nxt;
        end
    end

    // Stack contents need no reset; depth alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (w_push && (r_depth == DEPTH_W'(i))) begin
                r_stack[i] <= r_head;
            end
        end
    end

    assign cmd_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_MOVING);
    assign head_ptr    = r_head;
    assign head_step   = r_head_step;
    assign bound_fault = r_bound_fault;
    assign stack_err   = r_stack_err;
    assign stack_empty = w_empty;
    assign stack_full  = w_full;

endmodule

// File: tb/tb_head_ptr_unit.sv
// Scoreboard bench for head_ptr_unit: one wrapping and one saturating instance, directed
// commands push expected snapshots tagged with a cycle, a monitor pops and compares them.
module tb_head_ptr_unit;

    localparam int AW = 8;
    localparam int SW = 4;

    localparam logic [2:0] NOP = 3'd0, MVR = 3'd1, MVL = 3'd2, LOAD = 3'd3;
    localparam logic [2:0] PUSH = 3'd4, POP = 3'd5, CLR = 3'd6, RSVD = 3'd7;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid   [2];
    logic [2:0]    cmd_op      [2];
    logic [SW-1:0] cmd_amount  [2];
    logic [AW-1:0] load_value  [2];
    logic          cmd_ready   [2];
    logic [AW-1:0] head_ptr    [2];
    logic          head_step   [2];
    logic          busy        [2];
    logic          bound_fault [2];
    logic          stack_err   [2];
    logic          stack_empty [2];
    logic          stack_full  [2];

    always #5 clk = ~clk;

    head_ptr_unit #(.ADDR_W(AW), .STEP_W(SW), .STACK_DEPTH(4), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_op(cmd_op[0]),
        .cmd_amount(cmd_amount[0]), .load_value(load_value[0]), .cmd_ready(cmd_ready[0]),
        .head_ptr(head_ptr[0]), .head_step(head_step[0]), .busy(busy[0]),
        .bound_fault(bound_fault[0]), .stack_err(stack_err[0]),
        .stack_empty(stack_empty[0]), .stack_full(stack_full[0]));

    head_ptr_unit #(.ADDR_W(AW), .STEP_W(SW), .STACK_DEPTH(4), .WRAP_MODE(0)) u_sat (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_op(cmd_op[1]),
        .cmd_amount(cmd_amount[1]), .load_value(load_value[1]), .cmd_ready(cmd_ready[1]),
        .head_ptr(head_ptr[1]), .head_step(head_step[1]), .busy(busy[1]),
        .bound_fault(bound_fault[1]), .stack_err(stack_err[1]),
        .stack_empty(stack_empty[1]), .stack_full(stack_full[1]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot = {head, ready, busy, step, bound_fault, stack_err, empty, full}
    typedef struct {
        int          cyc;
        int          d;
        string       name;
        logic [14:0] exp;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [14:0] snap(int d);
        return {head_ptr[d], cmd_ready[d], busy[d], head_step[d], bound_fault[d],
                stack_err[d], stack_empty[d], stack_full[d]};
    endfunction

    task automatic expect_at(int d, int k, string name, logic [7:0] h, logic [6:0] f);
        exp_t e;
        e.cyc  = cyc + k;
        e.d    = d;
        e.name = name;
        e.exp  = {h, f};
        q.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(int d, logic [2:0] op, logic [SW-1:0] amt, logic [AW-1:0] val);
        cmd_valid[d]  = 1'b1;
        cmd_op[d]     = op;
        cmd_amount[d] = amt;
        load_value[d] = val;
        tick(1);
        cmd_valid[d]  = 1'b0;
    endtask

    initial begin
        exp_t        e;
        logic [14:0] a;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s dut%0d: sample slot missed (cycle %0d, now %0d)",
                             e.name, e.d, e.cyc, cyc);
                end else begin
                    a = snap(e.d);
                    if (a !== e.exp) begin
                        errors++;
                        $display("FAIL %s dut%0d cyc%0d: got head=%02h rdy/busy/step/bf/se/emp/full=%07b, want head=%02h %07b",
                                 e.name, e.d, cyc, a[14:7], a[6:0], e.exp[14:7], e.exp[6:0]);
                    end
                end
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_op[d] = '0; cmd_amount[d] = '0; load_value[d] = '0;
        end
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        expect_at(0, 0, "reset_wrap", 8'h00, 7'b1000010);
        expect_at(1, 0, "reset_sat",  8'h00, 7'b1000010);
        tick(1);

        issue(0, MVR, 4'd3, 8'h00);
        expect_at(0, 0, "mvr3_s1",   8'h01, 7'b0110010);
        expect_at(0, 1, "mvr3_s2",   8'h02, 7'b0110010);
        expect_at(0, 2, "mvr3_s3",   8'h03, 7'b1010010);
        expect_at(0, 3, "mvr3_done", 8'h03, 7'b1000010);
        tick(3);

        // MVL offered while busy must be dropped
        issue(0, MVR, 4'd4, 8'h00);
        expect_at(0, 0, "mvr4_s1",   8'h04, 7'b0110010);
        expect_at(0, 1, "mvr4_s2",   8'h05, 7'b0110010);
        expect_at(0, 2, "mvr4_s3",   8'h06, 7'b0110010);
        expect_at(0, 3, "mvr4_s4",   8'h07, 7'b1010010);
        expect_at(0, 4, "mvr4_done", 8'h07, 7'b1000010);
        issue(0, MVL, 4'd5, 8'h00);
        tick(3);

        issue(0, NOP, 4'd0, 8'h55);
        expect_at(0, 0, "nop", 8'h07, 7'b1000010);
        issue(0, RSVD, 4'd3, 8'h55);
        expect_at(0, 0, "op7", 8'h07, 7'b1000010);
        issue(0, MVR, 4'd0, 8'h00);
        expect_at(0, 0, "mvr0", 8'h07, 7'b1000010);
        issue(0, MVL, 4'd0, 8'h00);
        expect_at(0, 0, "mvl0", 8'h07, 7'b1000010);

        issue(0, LOAD, 4'd0, 8'hFE);
        expect_at(0, 0, "load_fe", 8'hFE, 7'b1000010);
        issue(0, MVR, 4'd3, 8'h00);
        expect_at(0, 0, "wrap_r1", 8'hFF, 7'b0110010);
        expect_at(0, 1, "wrap_r2", 8'h00, 7'b0110010);
        expect_at(0, 2, "wrap_r3", 8'h01, 7'b1010010);
        tick(2);
        issue(0, LOAD, 4'd0, 8'h00);
        expect_at(0, 0, "load_00", 8'h00, 7'b1000010);
        issue(0, MVL, 4'd2, 8'h00);
        expect_at(0, 0, "wrap_l1", 8'hFF, 7'b0110010);
        expect_at(0, 1, "wrap_l2", 8'hFE, 7'b1010010);
        tick(1);

        for (int i = 1; i <= 4; i++) begin
            issue(0, LOAD, 4'd0, 8'(i * 16));
            issue(0, PUSH, 4'd0, 8'h00);
            expect_at(0, 0, "push", 8'(i * 16), {6'b100000, (i == 4)});
        end
        issue(0, PUSH, 4'd0, 8'h00);
        expect_at(0, 0, "push_full", 8'h40, 7'b1000101);
        issue(0, CLR, 4'd0, 8'h00);
        expect_at(0, 0, "clr_serr", 8'h40, 7'b1000001);
        for (int i = 4; i >= 1; i--) begin
            issue(0, POP, 4'd0, 8'h00);
            expect_at(0, 0, "pop", 8'(i * 16), {5'b10000, (i == 1), 1'b0});
        end
        issue(0, POP, 4'd0, 8'h00);
        expect_at(0, 0, "pop_empty", 8'h10, 7'b1000110);
        issue(0, CLR, 4'd0, 8'h00);
        expect_at(0, 0, "clr_pop", 8'h10, 7'b1000010);

        issue(1, LOAD, 4'd0, 8'hFD);
        expect_at(1, 0, "sat_load", 8'hFD, 7'b1000010);
        issue(1, MVR, 4'd5, 8'h00);
        expect_at(1, 0, "sat_s1",    8'hFE, 7'b0110010);
        expect_at(1, 1, "sat_s2",    8'hFF, 7'b0110010);
        expect_at(1, 2, "sat_block", 8'hFF, 7'b1001010);
        expect_at(1, 3, "sat_hold",  8'hFF, 7'b1001010);
        tick(3);
        issue(1, CLR, 4'd0, 8'h00);
        expect_at(1, 0, "sat_clr", 8'hFF, 7'b1000010);
        issue(1, LOAD, 4'd0, 8'h00);
        issue(1, MVL, 4'd1, 8'h00);
        expect_at(1, 0, "sat_low", 8'h00, 7'b1001010);
        issue(1, CLR, 4'd0, 8'h00);
        expect_at(1, 0, "sat_clr2", 8'h00, 7'b1000010);

        issue(0, LOAD, 4'd0, 8'h00);
        issue(0, PUSH, 4'd0, 8'h00);
        expect_at(0, 0, "pre_rst_push", 8'h00, 7'b1000000);
        issue(0, MVR, 4'd15, 8'h00);
        expect_at(0, 0, "long_s1", 8'h01, 7'b0110000);
        expect_at(0, 3, "long_s4", 8'h04, 7'b0110000);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        expect_at(0, 0, "mid_rst",      8'h00, 7'b1000010);
        expect_at(1, 0, "mid_rst_sat",  8'h00, 7'b1000010);
        expect_at(0, 1, "post_rst",     8'h00, 7'b1000010);

        for (int i = 0; i < 20 && q.size() > 0; i++) tick(1);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never sampled, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
